tick_rate_sequencer: RTL and testbench
======================================

Name: tick_rate_sequencer

Overview:
Run-time programmable tick scheduler for the sine-wave datapath. It sequences sample updates (phase step / DAC write enable) at a software-selected period, in either continuous or fixed-length burst mode. It replaces the fixed compile-time tick period with start/stop control and a ready-gated single-cycle tick. It also reports overrun when the consumer is not ready.

Parameters:
PERIOD_W, 32, width of the period input and internal counter
BURST_W, 16, width of burst length and tick index
MIN_PERIOD, 2, smallest period honoured; smaller requests are clamped to this value

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  synchronous reset, active-high
start  input  1  level-sampled; in IDLE begins a run
stop  input  1  level-sampled; aborts a run
period  input  PERIOD_W  tick period in clk cycles, latched on start
burst_len  input  BURST_W  ticks per run, latched on start; 0 = continuous
ready  input  1  consumer can accept a tick this cycle
tick  output  1  single-cycle enable to the datapath
busy  output  1  high while in RUN
done  output  1  single-cycle pulse on burst completion
overrun  output  1  sticky: a tick was due while ready was low
tick_index  output  BURST_W  number of tick slots elapsed in the current run

Behaviour:
- All state and outputs are registered on the rising edge of clk.
- Reset: state=IDLE, counter=0, tick=0, busy=0, done=0, overrun=0, tick_index=0, latched period=MIN_PERIOD, latched burst_len=0. Reset overrides every other input, including in mid-run.
- States: IDLE and RUN.
- IDLE:
  - If start=1 and stop=0 at edge E0: latch period_l = max(period, MIN_PERIOD) and burst_l = burst_len. Set counter=0, tick_index=0, overrun=0, busy=1, state=RUN.
  - start and stop both high: stop wins and the block stays IDLE.
- RUN, each edge:
  - If stop=1: state=IDLE, busy=0, tick=0, done=0, counter=0. tick_index and overrun hold their values.
  - Else if counter == period_l-1 (a tick slot):
    - counter<=0, tick_index<=tick_index+1 (wraps modulo 2^BURST_W).
    - tick<=ready. If ready=0, set overrun<=1 and drop the tick; the slot still counts.
    - If burst_l != 0 and tick_index+1 == burst_l: done<=1, busy<=0, state=IDLE.
  - Else: counter<=counter+1, tick<=0, done<=0.
- Timing:
  - First tick (or dropped slot) occurs at edge E0+period_l; tick is high for the following cycle.
  - Later slots occur every period_l cycles.
  - tick and done are high in the same cycle for the last burst slot.
- start while in RUN is ignored. period and burst_len changes during RUN have no effect until the next start.
- done is high only for the single cycle after a burst completes. It is never asserted on stop or in continuous mode.
- A new start is accepted in the cycle directly after done, i.e. back-to-back bursts with no idle gap.
- Continuous mode: tick_index wraps and never terminates the run.
- ready is sampled only on tick-slot edges. There is no retry or queuing of dropped ticks.
- The counter is an unsigned PERIOD_W-bit value. period_l-1 never underflows because of the MIN_PERIOD clamp.

Test Plan:
- Reset, then period=5, burst_len=3, ready=1, start pulse at edge E0:
  - tick high in the cycles after edges E0+5, E0+10, E0+15.
  - done coincident with the third tick; busy drops with it; tick_index=3; overrun=0.
- period=0 and period=1:
  - Both clamp to 2, giving a tick every 2 cycles.
  - period=2 gives the same result.
- Continuous run, burst_len=0, period=4, ready held low for slot 2 only:
  - Slot 2 produces no tick and sets overrun=1; overrun stays set.
  - Slots 1 and 3 tick normally; tick_index keeps incrementing; done is never asserted.
- Stop asserted one cycle before the 2nd slot (period=10):
  - No tick at E0+20; IDLE on the next edge; busy=0; done=0; tick_index=1.
- start and stop high together in IDLE:
  - Stays IDLE. A later start clears overrun and tick_index to 0.
- rst asserted mid-run with counter=7:
  - All outputs are 0 the next cycle and no tick is emitted.
  - start accepted on the cycle after rst deasserts gives its first tick exactly period cycles later.
  - Also check back-to-back bursts: start held high through done restarts with no gap.

Source files
------------

// File: rtl/tick_rate_sequencer.sv
// Run-time programmable tick scheduler: issues ready-gated single-cycle ticks
// at a latched period, in continuous or fixed-length burst mode.
module tick_rate_sequencer #(
    parameter int unsigned PERIOD_W   = 32,
    parameter int unsigned BURST_W    = 16,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [BURST_W-1:0]  burst_len,
    input  logic                ready,
    output logic                tick,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic [BURST_W-1:0]  tick_index
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] counter;
    logic [PERIOD_W-1:0] period_l;
    logic [BURST_W-1:0]  burst_l;
    logic                slot;
    logic [BURST_W-1:0]  index_next;

    // The MIN_PERIOD clamp keeps period_l-1 from underflowing.
    assign slot       = (counter == period_l - PERIOD_W'(1));
    assign index_next = tick_index + BURST_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            period_l   <= MIN_P;
            burst_l    <= '0;
            tick       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            tick_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tick <= 1'b0;
                    done <= 1'b0;
                    if (start && !stop) begin
                        period_l   <= (period < MIN_P) ? MIN_P : period;
                        burst_l    <= burst_len;
                        counter    <= '0;
                        tick_index <= '0;
                        overrun    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tick    <= 1'b0;
                        done    <= 1'b0;
                        counter <= '0;
                    end else if (slot) begin
                        // A slot counts even when the tick is dropped for !ready.
                        counter    <= '0;
                        tick_index <= index_next;
                        tick       <= ready;
                        if (!ready) begin
                            overrun <= 1'b1;
                        end
                        if ((burst_l != '0) && (index_next == burst_l)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            done <= 1'b0;
                        end
                    end else begin
                        counter <= counter + PERIOD_W'(1);
                        tick    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_rate_sequencer.sv
// Scoreboard bench for tick_rate_sequencer: stimulus queues expected tick/done
// events by edge number; a negedge monitor pops and compares them.
module tb_tick_rate_sequencer;

    localparam int unsigned PERIOD_W = 32;
    localparam int unsigned BURST_W  = 16;

    logic                clk;
    logic                rst;
    logic                start;
    logic                stop;
    logic [PERIOD_W-1:0] period;
    logic [BURST_W-1:0]  burst_len;
    logic                ready;
    logic                tick;
    logic                busy;
    logic                done;
    logic                overrun;
    logic [BURST_W-1:0]  tick_index;

    tick_rate_sequencer #(
        .PERIOD_W  (PERIOD_W),
        .BURST_W   (BURST_W),
        .MIN_PERIOD(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .burst_len (burst_len),
        .ready     (ready),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .tick_index(tick_index)
    );

    typedef struct {
        int   e;
        logic t;
        logic d;
        int   idx;
        logic b;
        logic o;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp_v);
        end
    endtask

    task automatic push(input int e, input logic t, input logic d, input int idx,
                        input logic b, input logic o);
        exp_t x;
        x.e = e; x.t = t; x.d = d; x.idx = idx; x.b = b; x.o = o;
        sb.push_back(x);
    endtask

    // Monitor: every cycle presenting tick or done must match the queue head.
    always @(negedge clk) begin
        if (rst !== 1'b1 && (tick === 1'b1 || done === 1'b1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", edge_n, -1);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("ev_edge", edge_n, x.e);
                chk("ev_tick", int'(tick), int'(x.t));
                chk("ev_done", int'(done), int'(x.d));
                chk("ev_index", int'(tick_index), x.idx);
                chk("ev_busy", int'(busy), int'(x.b));
                chk("ev_overrun", int'(overrun), int'(x.o));
            end
        end
    end

    task automatic wait_until(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    // Called at a negedge; returns the edge that sampled start.
    task automatic do_start(input int p, input int bl, output int e0);
        period    = PERIOD_W'(p);
        burst_len = BURST_W'(bl);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        e0        = edge_n;
    endtask

    initial begin
        int e0;
        int e1;
        int e2;
        rst = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b1;
        period = '0; burst_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_index", int'(tick_index), 0);
        rst = 1'b0;
        @(negedge clk);

        // Burst of 3 at period 5.
        do_start(5, 3, e0);
        chk("b3_busy_start", int'(busy), 1);
        push(e0 + 5, 1, 0, 1, 1, 0);
        push(e0 + 10, 1, 0, 2, 1, 0);
        push(e0 + 15, 1, 1, 3, 0, 0);
        wait_until(e0 + 17);
        chk("b3_busy_end", int'(busy), 0);
        chk("b3_index_end", int'(tick_index), 3);
        chk("b3_done_end", int'(done), 0);

        // Period clamp: 0, 1 and 2 all tick every 2 cycles.
        for (int p = 0; p <= 2; p++) begin
            do_start(p, 2, e0);
            push(e0 + 2, 1, 0, 1, 1, 0);
            push(e0 + 4, 1, 1, 2, 0, 0);
            wait_until(e0 + 6);
        end

        // Continuous, period 4, ready low for slot 2 only.
        do_start(4, 0, e0);
        push(e0 + 4, 1, 0, 1, 1, 0);
        push(e0 + 12, 1, 0, 3, 1, 1);
        wait_until(e0 + 7);
        ready = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        chk("ovr_tick_dropped", int'(tick), 0);
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_index", int'(tick_index), 2);
        wait_until(e0 + 13);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("cont_stop_busy", int'(busy), 0);
        chk("cont_stop_done", int'(done), 0);
        chk("cont_stop_ovr_hold", int'(overrun), 1);
        chk("cont_stop_index_hold", int'(tick_index), 3);
        repeat (6) @(negedge clk);

        // start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1; period = 32'd3;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (4) @(negedge clk);
        chk("ss_busy", int'(busy), 0);
        chk("ss_index", int'(tick_index), 3);
        chk("ss_overrun", int'(overrun), 1);

        // Period 10, stop one cycle before slot 2; start clears overrun/index.
        do_start(10, 0, e0);
        chk("s10_ovr_cleared", int'(overrun), 0);
        chk("s10_index_cleared", int'(tick_index), 0);
        push(e0 + 10, 1, 0, 1, 1, 0);
        wait_until(e0 + 18);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("s10_busy", int'(busy), 0);
        chk("s10_done", int'(done), 0);
        chk("s10_index", int'(tick_index), 1);
        wait_until(e0 + 23);

        // Reset mid-run on what would have been a tick slot (counter=7, period 8).
        do_start(8, 0, e0);
        wait_until(e0 + 7);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_tick", int'(tick), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_overrun", int'(overrun), 0);
        chk("mrst_index", int'(tick_index), 0);
        rst = 1'b0;
        period = 32'd6; burst_len = 16'd2; start = 1'b1;
        e1 = edge_n + 1;
        push(e1 + 6, 1, 0, 1, 1, 0);
        push(e1 + 12, 1, 1, 2, 0, 0);
        // start held through done restarts on the very next edge.
        e2 = e1 + 13;
        push(e2 + 6, 1, 0, 1, 1, 0);
        push(e2 + 12, 1, 1, 2, 0, 0);
        wait_until(e2);
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_index", int'(tick_index), 0);
        chk("b2b_done_cleared", int'(done), 0);
        wait_until(e2 + 12);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("b2b_final_busy", int'(busy), 0);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
